cell_plot_scheduler: RTL
========================

Name: cell_plot_scheduler

Overview:
- Owns the single VGA adapter write port (colour, x, y, plot).
- Shares that port between two cell-paint requesters (req0 = live brush, req1 = slot/replay path) and a full-screen clear.
- Expands each accepted cell command into CELL_WIDTH x CELL_WIDTH pixel writes, one per clock, and sweeps the whole frame on clear.
- Sits between the drawing circuit and vga_adapter.

Parameters:
SCREEN_WIDTH, 160, frame width in pixels
SCREEN_HEIGHT, 120, frame height in pixels
CELL_WIDTH, 5, cell edge length in pixels
CLEAR_COLOUR, 3'b111, colour written by a clear sweep (white background)

Ports:
iClk  in  1  system clock (CLOCK_50)
iResetn  in  1  asynchronous active-low reset
iValid0  in  1  req0 command valid; held until oAck0
iCellX0  in  8  req0 cell column
iCellY0  in  8  req0 cell row
iColour0  in  3  req0 colour
iValid1  in  1  req1 command valid; held until oAck1
iCellX1  in  8  req1 cell column
iCellY1  in  8  req1 cell row
iColour1  in  3  req1 colour
iClear  in  1  clear request, single-cycle pulse or level
oAck0  out  1  one-cycle accept pulse for req0
oAck1  out  1  one-cycle accept pulse for req1
oErr  out  1  one-cycle pulse with an ack when the command was out of range
oBusy  out  1  high whenever state is not IDLE
oX_pixel  out  $clog2(SCREEN_WIDTH)+1  pixel x to vga_adapter
oY_pixel  out  $clog2(SCREEN_HEIGHT)+1  pixel y to vga_adapter
oColour  out  3  pixel colour to vga_adapter
oPlot  out  1  write enable to vga_adapter

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any cycle including mid-sweep) aborts immediately and forces:
  - state = IDLE, clear-pending = 0, round-robin pointer = 1 (req0 wins the first tie);
  - all outputs = 0.
- States: IDLE, CELL, CLEAR.
- Clear-pending flag:
  - set by iClear in IDLE or CELL;
  - iClear is ignored in CLEAR, because the running sweep covers it.
- IDLE arbitration, evaluated every cycle, in priority order:
  1. clear-pending → go to CLEAR; clear-pending is cleared.
  2. Otherwise, if exactly one valid is asserted, grant it.
  3. If both are asserted, grant the requester not granted last; the pointer updates on every grant.
- Grant cycle T:
  - assert oAck for one cycle;
  - latch cell x, cell y and colour;
  - range check: cellX*CELL_WIDTH+CELL_WIDTH > SCREEN_WIDTH or cellY*CELL_WIDTH+CELL_WIDTH > SCREEN_HEIGHT.
  - If out of range: assert oErr with the ack, stay in IDLE, no plots.
  - Otherwise go to CELL.
- Requesters may deassert valid the cycle after ack. Data is not sampled again.
- CELL:
  - offset counters px, py start at 0; px advances fastest (raster order).
  - Each cycle T+1..T+CELL_WIDTH^2: oPlot=1, oX_pixel = cellX*CELL_WIDTH+px, oY_pixel = cellY*CELL_WIDTH+py, oColour = latched colour.
  - After px=py=CELL_WIDTH-1, return to IDLE. oPlot=0 at T+CELL_WIDTH^2+1.
  - The earliest next ack is T+CELL_WIDTH^2+1.
- CLEAR:
  - sweeps x = 0..SCREEN_WIDTH-1 fastest, y = 0..SCREEN_HEIGHT-1;
  - one plot per cycle, oColour = CLEAR_COLOUR, SCREEN_WIDTH*SCREEN_HEIGHT plots total (19200 at default);
  - then returns to IDLE.
- Valid requests are never acked while busy; they wait.
- Arithmetic: products use full output width; no truncation for in-range cells.
- oPlot=0 whenever state is IDLE. oX/oY/oColour hold their last values when oPlot=0.

Test Plan:
- Reset, then req0 (cell 2,3, colour 3'b100) → oAck0 at T; 25 plots at T+1..T+25; x 10..14, y 15..19 in raster order; oBusy low at T+26.
- req0 and req1 valid together and held → acks alternate 0,1,0,1; each ack is followed by exactly 25 plots of that requester's colour.
- iClear pulse during a req0 cell → cell finishes all 25 plots; next cycle CLEAR starts; 19200 plots of 3'b111 covering (0,0)..(159,119); a second iClear mid-sweep produces no extra sweep.
- iClear and req1 valid in the same IDLE cycle → CLEAR runs first; oAck1 comes on the cycle after the sweep ends.
- req1 cell (32,0) (x 160 ≥ 160) → oAck1 and oErr together; zero plots; state stays IDLE.
- iResetn low at plot 10 of a CELL → all outputs 0 immediately; after release, no remaining plots; pointer back to favour req0.

Source files
------------

// File: rtl/cell_plot_scheduler.sv
// Owns the single vga_adapter write port: arbitrates two cell-paint requesters
// and a full-screen clear, expanding each grant into one pixel write per clock.
module cell_plot_scheduler #(
    parameter int unsigned SCREEN_WIDTH  = 160,
    parameter int unsigned SCREEN_HEIGHT = 120,
    parameter int unsigned CELL_WIDTH    = 5,
    parameter logic [2:0]  CLEAR_COLOUR  = 3'b111
) (
    input  logic                           iClk,
    input  logic                           iResetn,
    input  logic                           iValid0,
    input  logic [7:0]                     iCellX0,
    input  logic [7:0]                     iCellY0,
    input  logic [2:0]                     iColour0,
    input  logic                           iValid1,
    input  logic [7:0]                     iCellX1,
    input  logic [7:0]                     iCellY1,
    input  logic [2:0]                     iColour1,
    input  logic                           iClear,
    output logic                           oAck0,
    output logic                           oAck1,
    output logic                           oErr,
    output logic                           oBusy,
    output logic [$clog2(SCREEN_WIDTH):0]  oX_pixel,
    output logic [$clog2(SCREEN_HEIGHT):0] oY_pixel,
    output logic [2:0]                     oColour,
    output logic                           oPlot
);
    localparam int unsigned XW = $clog2(SCREEN_WIDTH) + 1;
    localparam int unsigned YW = $clog2(SCREEN_HEIGHT) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CELL, S_CLEAR} state_t;

    state_t        state, state_next;
    logic          clear_pend, clear_pend_next;
    logic          last_grant, last_grant_next;
    logic [XW-1:0] cnt_x, cnt_x_next, base_x, base_x_next;
    logic [YW-1:0] cnt_y, cnt_y_next, base_y, base_y_next;
    logic [2:0]    colour_q, colour_next;
    logic          ack0_next, ack1_next, err_next, busy_next, plot_next;
    logic [XW-1:0] x_next;
    logic [YW-1:0] y_next;
    logic [2:0]    col_out_next;

    logic          pick1;
    logic [7:0]    sel_x, sel_y;
    logic [2:0]    sel_col;
    logic [15:0]   end_x, end_y;
    logic          out_of_range;

    // Requester selection: on a tie, favour the one not granted last.
    always_comb begin
        pick1        = iValid1 && (!iValid0 || !last_grant);
        sel_x        = pick1 ? iCellX1 : iCellX0;
        sel_y        = pick1 ? iCellY1 : iCellY0;
        sel_col      = pick1 ? iColour1 : iColour0;
        end_x        = 16'(sel_x) * 16'(CELL_WIDTH) + 16'(CELL_WIDTH);
        end_y        = 16'(sel_y) * 16'(CELL_WIDTH) + 16'(CELL_WIDTH);
        out_of_range = (end_x > 16'(SCREEN_WIDTH)) || (end_y > 16'(SCREEN_HEIGHT));
    end

    always_comb begin
        state_next      = state;
        clear_pend_next = clear_pend;
        last_grant_next = last_grant;
        cnt_x_next      = cnt_x;
        cnt_y_next      = cnt_y;
        base_x_next     = base_x;
        base_y_next     = base_y;
        colour_next     = colour_q;
        ack0_next       = 1'b0;
        ack1_next       = 1'b0;
        err_next        = 1'b0;
        plot_next       = 1'b0;
        x_next          = oX_pixel;
        y_next          = oY_pixel;
        col_out_next    = oColour;

        if (iClear && state != S_CLEAR)
            clear_pend_next = 1'b1;

        case (state)
            S_IDLE: begin
                if (clear_pend || iClear) begin
                    state_next      = S_CLEAR;
                    clear_pend_next = 1'b0;
                    cnt_x_next      = '0;
                    cnt_y_next      = '0;
                // No grant in the ack cycle: a rejected requester may still hold valid.
                end else if ((iValid0 || iValid1) && !(oAck0 || oAck1)) begin
                    last_grant_next = pick1;
                    ack0_next       = !pick1;
                    ack1_next       = pick1;
                    if (out_of_range) begin
                        err_next = 1'b1;
                    end else begin
                        state_next  = S_CELL;
                        base_x_next = XW'(end_x - 16'(CELL_WIDTH));
                        base_y_next = YW'(end_y - 16'(CELL_WIDTH));
                        colour_next = sel_col;
                        cnt_x_next  = '0;
                        cnt_y_next  = '0;
                    end
                end
            end
            S_CELL: begin
                plot_next    = 1'b1;
                x_next       = base_x + cnt_x;
                y_next       = base_y + cnt_y;
                col_out_next = colour_q;
                if (cnt_x == XW'(CELL_WIDTH - 1)) begin
                    cnt_x_next = '0;
                    if (cnt_y == YW'(CELL_WIDTH - 1))
                        state_next = S_IDLE;
                    else
                        cnt_y_next = cnt_y + YW'(1);
                end else begin
                    cnt_x_next = cnt_x + XW'(1);
                end
            end
            S_CLEAR: begin
                plot_next    = 1'b1;
                x_next       = cnt_x;
                y_next       = cnt_y;
                col_out_next = CLEAR_COLOUR;
                if (cnt_x == XW'(SCREEN_WIDTH - 1)) begin
                    cnt_x_next = '0;
                    if (cnt_y == YW'(SCREEN_HEIGHT - 1))
                        state_next = S_IDLE;
                    else
                        cnt_y_next = cnt_y + YW'(1);
                end else begin
                    cnt_x_next = cnt_x + XW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Busy also covers the cycle that presents the final pixel.
        busy_next = (state_next != S_IDLE) || plot_next;
    end

    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            state      <= S_IDLE;
            clear_pend <= 1'b0;
            last_grant <= 1'b1;
            cnt_x      <= '0;
            cnt_y      <= '0;
            base_x     <= '0;
            base_y     <= '0;
            colour_q   <= '0;
            oAck0      <= 1'b0;
            oAck1      <= 1'b0;
            oErr       <= 1'b0;
            oBusy      <= 1'b0;
            oPlot      <= 1'b0;
            oX_pixel   <= '0;
            oY_pixel   <= '0;
            oColour    <= '0;
        end else begin
            state      <= state_next;
            clear_pend <= clear_pend_next;
            last_grant <= last_grant_next;
            cnt_x      <= cnt_x_next;
            cnt_y      <= cnt_y_next;
            base_x     <= base_x_next;
            base_y     <= base_y_next;
            colour_q   <= colour_next;
            oAck0      <= ack0_next;
            oAck1      <= ack1_next;
            oErr       <= err_next;
            oBusy      <= busy_next;
            oPlot      <= plot_next;
            oX_pixel   <= x_next;
            oY_pixel   <= y_next;
            oColour    <= col_out_next;
        end
    end
endmodule
